vector_collector: RTL
=====================

# vector_collector

Upstream adapter feeding the debugger's `enqueue` / `eof_in` / `vector_in` inputs. It accepts a narrow K-lane element stream from the traced accelerator over a valid/ready handshake and packs it into N-lane vectors. It marks end-of-tensor and end-of-step in the 2-bit eof, and zero-pads partial vectors. Capture is gated so that only whole tensors reach the debugger.

## Interface
- `N`, 8: output vector lanes; must equal debugger `N`.
- `K`, 2: input lanes per beat; N % K == 0.
- `DATA_WIDTH`, 32: element width.
- `CNT_W`, 16: width of the per-tensor vector counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  capture request; level, synchronous.
- `valid_in`  in  1  beat valid.
- `ready_out`  out  1  beat accept; beat is taken when valid_in && ready_out.
- `elem_in`  in  DATA_WIDTH x K  beat payload; lane 0 = earliest element.
- `last_in`  in  1  beat is the final beat of a tensor.
- `step_in`  in  1  tensor is the final one of a step; qualified by last_in.
- `enqueue`  out  1  one-cycle pulse; vector_out/eof valid.
- `eof`  out  2  bit0 = end of tensor, bit1 = end of step.
- `vector_out`  out  DATA_WIDTH x N  packed vector.
- `tensor_vectors`  out  CNT_W  vector count of the last completed tensor.
- `overflow`  out  1  sticky; a tensor exceeded 2^CNT_W-1 vectors.

## Operation
- Slot counter `slot`, 0..N/K-1. An accepted beat writes lanes [slot*K +: K] of the staging register.
- A vector completes when slot == N/K-1 or last_in is set on the accepted beat.
- On completion:
  - staging lanes not written in this vector are zero.
  - the output register loads the staging vector.
  - eof = {last_in & step_in, last_in}.
  - slot and staging clear.
- `in_tensor` flag: set on an accepted beat with !last_in; cleared on an accepted beat with last_in. It is tracked in every state.
- State machine (states in the package):
  - IDLE: beats discarded. If enable && !in_tensor, go to PASS. If enable && in_tensor, go to SYNC.
  - SYNC: beats discarded. An accepted last_in beat (itself discarded) moves to PASS, or to IDLE if enable is low.
  - PASS: beats packed. If !enable: go to IDLE when the tensor is closed (no in_tensor after this cycle's beat), otherwise go to DRAIN.
  - DRAIN: beats packed. An accepted last_in beat is emitted and the block moves to IDLE. enable rising in DRAIN moves to PASS with no gap.
- Vector counter: increments per emitted vector and saturates at 2^CNT_W-1.
  - Incrementing while already saturated sets overflow.
  - On an emitted last_in vector, tensor_vectors takes the final count and the counter clears.
- Discarded beats do not touch slot, staging, or the counter.

## Timing
- ready_out is 0 during reset and for the first cycle after release, then held at 1. The debugger never stalls, so no backpressure is needed.
- Latency: the completing beat at cycle t gives enqueue=1 with vector_out and eof at t+1.
- enqueue is high for exactly one cycle per vector.
- Peak rate: one vector every N/K beats. A last_in beat in slot 0 emits a vector each beat.
- vector_out and eof hold their value between pulses.
- Reset values: ready_out 0, enqueue 0, eof 0, vector_out all 0, tensor_vectors 0, overflow 0, state IDLE, slot 0, in_tensor 0.
- Reset mid-vector drops the partial vector; nothing is emitted.
- enable is sampled every cycle. A state change takes effect for the next cycle's beat.

## Structure
- `collector_pkg`:
  - `state_t` enum {IDLE, SYNC, PASS, DRAIN}.
  - `SLOTS = N/K`.
  - eof bit index constants `EOF_TENSOR = 0`, `EOF_STEP = 1`.
- One sub-module, `lane_packer`: slot counter, staging register and zero-pad/complete logic.
- The top level holds the FSM, in_tensor, the counter and the output registers.

## Test plan
All scenarios use N=8, K=2.
- **Full vector:** enable=1, beats {1,2},{3,4},{5,6},{7,8}, last on the 4th. One enqueue, vector_out=1..8, eof=01, tensor_vectors=1.
- **Padding and step mark:** 5 beats {1..10}, last+step on the 5th. Two enqueues; the second is {9,10,0,0,0,0,0,0} with eof=11; tensor_vectors=2.
- **Enable mid-tensor:** enable rises at beat 2 of a 6-beat tensor. No enqueue for that tensor; the next tensor passes fully.
- **Drain:** enable falls at beat 2 of a 6-beat tensor. All 6 beats are emitted (2 vectors, last eof=01), then IDLE and further beats are dropped.
- **Reset mid-vector:** reset asserted after 3 beats. All outputs are 0; after release, a fresh 4-beat tensor emits exactly 1..8.
- **Overflow:** CNT_W=2, a 4-vector tensor. overflow=1 on the 4th vector, tensor_vectors=3, and overflow stays set.

Source files
------------

// File: rtl/vector_collector_pkg.sv
// Shared types and constants for the vector collector: FSM states, default geometry, eof bit positions.
package collector_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        PASS  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int N_DEF = 8;
    localparam int K_DEF = 2;
    localparam int SLOTS = N_DEF / K_DEF;

    localparam int EOF_TENSOR = 0;
    localparam int EOF_STEP   = 1;
endpackage

// File: rtl/vector_collector_if.sv
// K-lane element beat stream from the traced accelerator (valid/ready; lane 0 is the earliest element).
interface vector_collector_if
    import collector_pkg::*;
#(
    parameter int K          = K_DEF,
    parameter int DATA_WIDTH = 32
);
    logic                          valid_in;
    logic                          ready_out;
    logic [K-1:0][DATA_WIDTH-1:0]  elem_in;
    logic                          last_in;
    logic                          step_in;

    modport master (output valid_in, elem_in, last_in, step_in, input ready_out);
    modport slave  (input valid_in, elem_in, last_in, step_in, output ready_out);
endinterface

// File: rtl/vector_collector_lane_packer.sv
// Packs K-lane beats into an N-lane staging vector; done/vec are combinational on the completing beat.
// Lanes above the completing slot are zero because staging is cleared after every completion.
module lane_packer
    import collector_pkg::*;
#(
    parameter int N          = N_DEF,
    parameter int K          = K_DEF,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          beat_en,
    input  logic [K-1:0][DATA_WIDTH-1:0]  elem,
    input  logic                          last,
    output logic                          done,
    output logic [N-1:0][DATA_WIDTH-1:0]  vec
);
    localparam int NSLOT  = N / K;
    localparam int SLOT_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;

    logic [SLOT_W-1:0]             slot;
    logic [N-1:0][DATA_WIDTH-1:0]  stage;

    always_comb begin
        vec = stage;
        for (int i = 0; i < N; i++) begin
            if (slot == SLOT_W'(i / K)) vec[i] = elem[i % K];
        end
    end

    assign done = beat_en && (last || (slot == SLOT_W'(NSLOT - 1)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot  <= '0;
            stage <= '0;
        end else if (beat_en) begin
            if (done) begin
                slot  <= '0;
                stage <= '0;
            end else begin
                slot  <= slot + 1'b1;
                stage <= vec;
            end
        end
    end
endmodule

// File: rtl/vector_collector.sv
// Gates a K-lane beat stream to whole tensors and emits N-lane vectors with eof marks, one cycle after the completing beat.
// Never stalls: ready_out is held high from the second cycle after reset release.
module vector_collector
    import collector_pkg::*;
#(
    parameter int N          = N_DEF,
    parameter int K          = K_DEF,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    vector_collector_if.slave             beat,
    output logic                          enqueue,
    output logic [1:0]                    eof,
    output logic [N-1:0][DATA_WIDTH-1:0]  vector_out,
    output logic [CNT_W-1:0]              tensor_vectors,
    output logic                          overflow
);
    state_t                        state, state_nxt;
    logic                          ready_q;
    logic                          in_tensor, in_tensor_nxt;
    logic                          acc, pack_en, done;
    logic [N-1:0][DATA_WIDTH-1:0]  vec_c;
    logic [CNT_W-1:0]              cnt, cnt_inc;
    logic                          cnt_sat;

    assign beat.ready_out = ready_q;
    assign acc            = beat.valid_in && ready_q;
    assign in_tensor_nxt  = acc ? !beat.last_in : in_tensor;
    assign pack_en        = acc && ((state == PASS) || (state == DRAIN));

    lane_packer #(
        .N          (N),
        .K          (K),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .clk     (clk),
        .reset   (reset),
        .beat_en (pack_en),
        .elem    (beat.elem_in),
        .last    (beat.last_in),
        .done    (done),
        .vec     (vec_c)
    );

    // Entry/exit decisions look at in_tensor after this cycle's beat, so a closing beat counts.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = in_tensor_nxt ? SYNC : PASS;
            SYNC:    if (acc && beat.last_in) state_nxt = enable ? PASS : IDLE;
            PASS:    if (!enable) state_nxt = in_tensor_nxt ? DRAIN : IDLE;
            DRAIN: begin
                if (enable)                   state_nxt = PASS;
                else if (acc && beat.last_in) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign cnt_sat = &cnt;
    assign cnt_inc = cnt_sat ? cnt : cnt + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ready_q   <= 1'b0;
            in_tensor <= 1'b0;
        end else begin
            state     <= state_nxt;
            ready_q   <= 1'b1;
            in_tensor <= in_tensor_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enqueue        <= 1'b0;
            eof            <= 2'b00;
            vector_out     <= '0;
            tensor_vectors <= '0;
            overflow       <= 1'b0;
            cnt            <= '0;
        end else begin
            enqueue <= done;
            if (done) begin
                vector_out      <= vec_c;
                eof[EOF_TENSOR] <= beat.last_in;
                eof[EOF_STEP]   <= beat.last_in & beat.step_in;
                if (cnt_sat) overflow <= 1'b1;
                if (beat.last_in) begin
                    tensor_vectors <= cnt_inc;
                    cnt            <= '0;
                end else begin
                    cnt <= cnt_inc;
                end
            end
        end
    end
endmodule
